// File: rtl/wb_queue.sv
// Writeback queue in front of the regfile write port: load/ALU results are queued in order
// and drained one per cycle. Define WB_QUEUE_BYPASS_EN to enable the forwarding lookup.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [AW-1:0]              ld_wa,
    input  logic [DW-1:0]              ld_wd,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_wa,
    input  logic [DW-1:0]              alu_wd,
    input  logic                       hold,
    output logic                       we,
    output logic [AW-1:0]              wa,
    output logic [DW-1:0]              wd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic [AW-1:0]              ra1,
    input  logic [AW-1:0]              ra2,
    output logic                       fwd1_hit,
    output logic [DW-1:0]              fwd1_data,
    output logic                       fwd2_hit,
    output logic [DW-1:0]              fwd2_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_wa [DEPTH];
    logic [DW-1:0] q_wd [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic          ld_fire;
    logic          alu_fire;
    logic          vld_p0;
    logic [AW-1:0] wa_p0;
    logic [DW-1:0] wd_p0;
    logic          pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;

    // Readiness looks only at the registered count, so a full queue stalls producers
    // even in a cycle where the head is being written out.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign ld_fire   = ld_valid && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // Enqueue stage: ld and alu fires are mutually exclusive; r0 results are acknowledged but dropped.
    assign wa_p0  = ld_fire ? ld_wa : alu_wa;
    assign wd_p0  = ld_fire ? ld_wd : alu_wd;
    assign vld_p0 = (ld_fire || alu_fire) && (wa_p0 != '0);

    // Drain stage: head entry drives the write port directly.
    assign pop = !empty && !hold;
    assign we  = pop;
    assign wa  = empty ? '0 : q_wa[rd_ptr];
    assign wd  = empty ? '0 : q_wd[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (vld_p0) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({vld_p0, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            q_wa[wr_ptr] <= wa_p0;
            q_wd[wr_ptr] <= wd_p0;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    // Walks from head to tail so the youngest matching entry wins.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] ra);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < cnt) && (ra != '0) && (q_wa[idx] == ra))
                res = {1'b1, q_wd[idx]};
        end
        return res;
    endfunction

    assign {fwd1_hit, fwd1_data} = fwd_lookup(ra1);
    assign {fwd2_hit, fwd2_data} = fwd_lookup(ra2);
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: expected regfile writes are queued at issue time and a
// negedge monitor checks every we=1 cycle against them; status outputs are checked directly.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AW    = 5;

    logic          clk;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_wa;
    logic [DW-1:0] ld_wd;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_wa;
    logic [DW-1:0] alu_wd;
    logic          hold;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          fwd1_hit;
    logic [DW-1:0] fwd1_data;
    logic          fwd2_hit;
    logic [DW-1:0] fwd2_data;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  passed = 0;

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .hold(hold), .we(we), .wa(wa), .wd(wd),
        .count(count), .full(full), .empty(empty),
        .ra1(ra1), .ra2(ra2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a load result for one cycle; expect_write queues it on the scoreboard.
    task automatic issue_ld(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
        ld_valid = 1'b1;
        ld_wa    = a;
        ld_wd    = d;
        if (expect_write) sb.push_back('{wa: a, wd: d});
        step();
        ld_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && we) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got wa=%0d wd=0x%0h, expected no write at %0t", wa, wd, $time);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_wa", 32'(wa), 32'(e.wa));
                chk("wb_wd", 32'(wd), 32'(e.wd));
            end
        end
    end

    initial begin
        logic exp_hit;
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_wa     = '0;
        ld_wd     = '0;
        alu_valid = 1'b0;
        alu_wa    = '0;
        alu_wd    = '0;
        hold      = 1'b0;
        ra1       = '0;
        ra2       = '0;
`ifdef WB_QUEUE_BYPASS_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif

        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_wa", 32'(wa), 0);
        chk("rst_wd", 32'(wd), 0);
        chk("rst_fwd1_hit", 32'(fwd1_hit), 0);
        chk("rst_fwd1_data", 32'(fwd1_data), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // 1: load beats ALU in the same cycle; ALU goes next cycle
        ld_valid  = 1'b1; ld_wa  = 5'd2; ld_wd  = 8'h5A;
        alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 8'hA5;
        sb.push_back('{wa: 5'd2, wd: 8'h5A});
        sb.push_back('{wa: 5'd3, wd: 8'hA5});
        @(negedge clk);
        chk("t1_ld_ready", 32'(ld_ready), 1);
        chk("t1_alu_ready_blocked", 32'(alu_ready), 0);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("t1_alu_ready", 32'(alu_ready), 1);
        chk("t1_we_latency", 32'(we), 1);
        step();
        alu_valid = 1'b0;
        repeat (3) step();
        chk("t1_empty", 32'(empty), 1);

        // 2: hold fills the queue, then four back-to-back writes
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) issue_ld(AW'(i), DW'(i), 1'b1);
        @(negedge clk);
        chk("t2_count", 32'(count), 4);
        chk("t2_full", 32'(full), 1);
        chk("t2_ld_ready", 32'(ld_ready), 0);
        chk("t2_alu_ready", 32'(alu_ready), 0);
        chk("t2_we_held", 32'(we), 0);
        step();
        hold = 1'b0;
        repeat (4) step();
        chk("t2_empty", 32'(empty), 1);

        // 3: result for r0 is acknowledged but never written
        alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 8'hFF;
        @(negedge clk);
        chk("t3_alu_ready", 32'(alu_ready), 1);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t3_count", 32'(count), 0);
        chk("t3_we", 32'(we), 0);
        step();

        // 4: forwarding returns the youngest match; r0 never hits
        hold = 1'b1;
        issue_ld(5'd3, 8'h11, 1'b1);
        issue_ld(5'd3, 8'h22, 1'b1);
        ra1 = 5'd3;
        ra2 = 5'd0;
        #1;
        chk("t4_fwd1_hit", 32'(fwd1_hit), 32'(exp_hit));
        chk("t4_fwd1_data", 32'(fwd1_data), exp_hit ? 32'h22 : 32'h0);
        chk("t4_fwd2_hit_r0", 32'(fwd2_hit), 0);
        chk("t4_fwd2_data_r0", 32'(fwd2_data), 0);
        ra2 = 5'd7;
        #1;
        chk("t4_fwd2_hit_miss", 32'(fwd2_hit), 0);
        ra1 = '0;
        ra2 = '0;
        step();
        hold = 1'b0;
        repeat (3) step();
        chk("t4_empty", 32'(empty), 1);

        // 6: full queue refuses a load even while draining; accepted next cycle, order kept across wrap
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) issue_ld(AW'(i), DW'(8'h30 + i), 1'b1);
        hold = 1'b0;
        ld_valid = 1'b1; ld_wa = 5'd5; ld_wd = 8'h35;
        sb.push_back('{wa: 5'd5, wd: 8'h35});
        @(negedge clk);
        chk("t6_ld_ready_full", 32'(ld_ready), 0);
        chk("t6_count_full", 32'(count), 4);
        step();
        @(negedge clk);
        chk("t6_ld_ready", 32'(ld_ready), 1);
        chk("t6_count_3", 32'(count), 3);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("t6_count_swap", 32'(count), 3);
        repeat (4) step();
        chk("t6_empty", 32'(empty), 1);

        // 5: reset mid-cycle discards queued entries with no stale write afterwards
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) issue_ld(AW'(i + 8), DW'(8'h40 + i), 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_we", 32'(we), 0);
        chk("t5_empty", 32'(empty), 1);
        step();
        reset = 1'b0;
        hold  = 1'b0;
        repeat (4) step();
        chk("t5_count_after", 32'(count), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
